// File: rtl/p23_clint_pkg.sv
// Shared constants and helpers for the core-local interruptor: register offsets,
// bus FSM states and byte-strobe merge.
package p23_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic {
        StIdle = 1'b0,
        StResp = 1'b1
    } bus_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/p23_clint_prescaler.sv
// Timer prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick in the cycle
// the count wraps back to 0.
module p23_clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/p23_clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp, msip, and a two-state bus
// FSM that acknowledges every access exactly one cycle after it is seen.
module p23_clint
    import p23_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        irq_msip,
    output logic        irq_mtip
);

    bus_state_e  state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mtip_q, mtip_d;
    logic        tick;
    logic        mtime_wr;
    logic [31:0] rd_word;
    logic [15:0] word_addr;
    logic        unused_addr_bits;

    assign word_addr        = {mem_addr[15:2], 2'b00};
    assign unused_addr_bits = ^mem_addr[1:0];

    p23_clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (mtime_wr),
        .tick  (tick)
    );

    always_comb begin
        rd_word = '0;
        case (word_addr)
            CLINT_MSIP:        rd_word = {31'b0, msip_q};
            CLINT_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
            CLINT_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
            CLINT_MTIME_LO:    rd_word = mtime_q[31:0];
            CLINT_MTIME_HI:    rd_word = mtime_q[63:32];
            default:           rd_word = '0;
        endcase
    end

    // Bus writes are applied after the tick increment so a write to mtime wins.
    always_comb begin
        state_d    = state_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        rdata_d    = rdata_q;
        mtime_wr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    state_d = StResp;
                    if (|mem_wstrb) begin
                        case (word_addr)
                            CLINT_MSIP: begin
                                if (mem_wstrb[0]) msip_d = mem_wdata[0];
                            end
                            CLINT_MTIMECMP_LO: mtimecmp_d[31:0] =
                                apply_wstrb(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
                            CLINT_MTIMECMP_HI: mtimecmp_d[63:32] =
                                apply_wstrb(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
                            CLINT_MTIME_LO: begin
                                mtime_d  = {mtime_q[63:32],
                                            apply_wstrb(mtime_q[31:0], mem_wdata, mem_wstrb)};
                                mtime_wr = 1'b1;
                            end
                            CLINT_MTIME_HI: begin
                                mtime_d  = {apply_wstrb(mtime_q[63:32], mem_wdata, mem_wstrb),
                                            mtime_q[31:0]};
                                mtime_wr = 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        rdata_d = rd_word;
                    end
                end
            end
            StResp: state_d = StIdle;
        endcase
    end

    assign mtip_d = (mtime_q >= mtimecmp_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            mtip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mem_ready = (state_q == StResp);
    assign mem_rdata = rdata_q;
    assign irq_msip  = msip_q;
    assign irq_mtip  = mtip_q;

endmodule

// File: tb/tb_p23_clint.sv
// Scoreboard bench for p23_clint: one instance with TICK_DIV=1 and one with
// TICK_DIV=4 share the address/data lines but have separate request strobes.
`timescale 1ns/1ps
module tb_p23_clint;
    import p23_clint_pkg::*;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid0, valid4;
    logic [3:0]  wstrb;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        rdy0, rdy4, msip0, msip4, mtip0, mtip4;
    logic [31:0] rdata0, rdata4;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_cnt0 = 0;
    bit   prev_rdy0 = 0;
    bit   prev_rdy4 = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    p23_clint #(.TICK_DIV(1)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (valid0),
        .mem_ready (rdy0),
        .mem_wstrb (wstrb),
        .mem_addr  (addr),
        .mem_wdata (wdata),
        .mem_rdata (rdata0),
        .irq_msip  (msip0),
        .irq_mtip  (mtip0)
    );

    p23_clint #(.TICK_DIV(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (valid4),
        .mem_ready (rdy4),
        .mem_wstrb (wstrb),
        .mem_addr  (addr),
        .mem_wdata (wdata),
        .mem_rdata (rdata4),
        .irq_msip  (msip4),
        .irq_mtip  (mtip4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per mem_ready pulse, compares read data.
    task automatic mon(input int t, input logic rdy, input logic [31:0] rd, input bit prev);
        exp_t e;
        bit   empty;
        if (rdy === 1'b1) begin
            if (prev) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_width[%0d]: got 2 consecutive cycles expected 1", t);
            end
            empty = (t == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (empty) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready[%0d]: got ready expected none", t);
            end else begin
                e = (t == 0) ? sb0.pop_front() : sb1.pop_front();
                if (e.is_rd) check(e.name, {32'b0, rd}, {32'b0, e.data});
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rdy0, rdata0, prev_rdy0);
        mon(1, rdy4, rdata4, prev_rdy4);
        if (rdy0 === 1'b1) rdy_cnt0++;
        prev_rdy0 = (rdy0 === 1'b1);
        prev_rdy4 = (rdy4 === 1'b1);
    end

    // Called just after a posedge; the request is sampled on the next edge.
    task automatic bus(input int t, input logic [15:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp, input string name);
        exp_t e;
        e.is_rd = (s == 4'b0000);
        e.data  = exp;
        e.name  = name;
        if (t == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        addr  = a;
        wstrb = s;
        wdata = d;
        if (t == 0) valid0 = 1'b1;
        else        valid4 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid4 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        reset  = 1'b1;
        valid0 = 1'b0;
        valid4 = 1'b0;
        addr   = '0;
        wstrb  = '0;
        wdata  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Make outputs non-zero, then reset asynchronously mid-access.
        bus(0, CLINT_MSIP, 4'hF, 32'h1, 32'h0, "msip_set_pre");
        bus(0, CLINT_MTIMECMP_LO, 4'h0, 32'h0, 32'hFFFF_FFFF, "cmp_lo_pre");
        check("pre_rst_msip", {63'b0, msip0}, 64'd1);
        addr   = CLINT_MTIMECMP_HI;
        wstrb  = 4'h0;
        valid0 = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_ready", {63'b0, rdy0}, 64'd0);
        check("rst_rdata", {32'b0, rdata0}, 64'd0);
        check("rst_msip", {63'b0, msip0}, 64'd0);
        check("rst_mtip", {63'b0, mtip0}, 64'd0);
        check("rst_rdata4", {32'b0, rdata4}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus(0, CLINT_MTIME_LO, 4'h0, 32'h0, 32'd2, "rst_mtime_lo");
        bus(0, CLINT_MTIMECMP_LO, 4'h0, 32'h0, 32'hFFFF_FFFF, "rst_cmp_lo");
        bus(0, CLINT_MTIMECMP_HI, 4'h0, 32'h0, 32'hFFFF_FFFF, "rst_cmp_hi");

        // Timer match with TICK_DIV=1.
        bus(0, CLINT_MTIMECMP_HI, 4'hF, 32'd0, 32'h0, "cmp_hi_w");
        bus(0, CLINT_MTIMECMP_LO, 4'hF, 32'd100, 32'h0, "cmp_lo_w");
        bus(0, CLINT_MTIME_LO, 4'hF, 32'd0, 32'h0, "mtime_lo_w");
        repeat (99) @(posedge clk);
        #1 check("mtip_at_equal", {63'b0, mtip0}, 64'd0);
        @(posedge clk);
        #1 check("mtip_rise", {63'b0, mtip0}, 64'd1);
        bus(0, CLINT_MTIMECMP_HI, 4'hF, 32'd1, 32'h0, "cmp_hi_w1");
        check("mtip_fall", {63'b0, mtip0}, 64'd0);

        // Prescaler and 64-bit wrap with TICK_DIV=4.
        bus(1, CLINT_MTIME_HI, 4'hF, 32'hFFFF_FFFF, 32'h0, "wrap_hi_w");
        bus(1, CLINT_MTIME_LO, 4'hF, 32'hFFFF_FFFE, 32'h0, "wrap_lo_w");
        repeat (3) @(posedge clk);
        #1 check("wrap_mtip_pre", {63'b0, mtip4}, 64'd0);
        @(posedge clk);
        #1 check("wrap_mtip_max", {63'b0, mtip4}, 64'd1);
        bus(1, CLINT_MTIME_LO, 4'h0, 32'h0, 32'hFFFF_FFFF, "wrap_rd_max");
        repeat (2) @(posedge clk);
        #1 check("wrap_mtip_clr", {63'b0, mtip4}, 64'd0);
        bus(1, CLINT_MTIME_LO, 4'h0, 32'h0, 32'h0, "wrap_rd_lo0");
        bus(1, CLINT_MTIME_HI, 4'h0, 32'h0, 32'h0, "wrap_rd_hi0");

        // Write to mtime lands exactly in a tick cycle.
        bus(1, CLINT_MTIME_HI, 4'hF, 32'h0, 32'h0, "coll_hi_w");
        repeat (2) @(posedge clk);
        #1;
        bus(1, CLINT_MTIME_LO, 4'hF, 32'd5, 32'h0, "coll_lo_w");
        bus(1, CLINT_MTIME_LO, 4'h0, 32'h0, 32'd5, "coll_rd_a");
        bus(1, CLINT_MTIME_LO, 4'h0, 32'h0, 32'd5, "coll_rd_b");
        bus(1, CLINT_MTIME_LO, 4'h0, 32'h0, 32'd6, "coll_rd_c");

        // Byte strobes and msip.
        bus(1, CLINT_MTIMECMP_LO, 4'b0101, 32'hAABB_CCDD, 32'h0, "strb_w");
        bus(1, CLINT_MTIMECMP_LO, 4'h0, 32'h0, 32'hFFBB_FFDD, "strb_rd");
        bus(1, CLINT_MTIMECMP_HI, 4'h0, 32'h0, 32'hFFFF_FFFF, "strb_rd_hi");
        bus(0, CLINT_MSIP, 4'hF, 32'h1, 32'h0, "msip_w1");
        check("msip_set", {63'b0, msip0}, 64'd1);
        bus(0, CLINT_MSIP, 4'h0, 32'h0, 32'h1, "msip_rd1");
        bus(0, CLINT_MSIP, 4'hF, 32'hFFFF_FFFE, 32'h0, "msip_w0");
        check("msip_clr", {63'b0, msip0}, 64'd0);
        bus(0, CLINT_MSIP, 4'h0, 32'h0, 32'h0, "msip_rd0");

        // Back-to-back with mem_valid held high, unmapped offset.
        c0 = rdy_cnt0;
        sb0.push_back('{1'b1, 32'h0, "unmapped_rd"});
        addr   = 16'h1234;
        wstrb  = 4'h0;
        wdata  = 32'h0;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        wstrb = 4'hF;
        wdata = 32'hFFFF_FFFF;
        sb0.push_back('{1'b0, 32'h0, "unmapped_wr"});
        @(posedge clk);
        @(posedge clk);
        #1 valid0 = 1'b0;
        @(posedge clk);
        #1 check("b2b_ready_count", 64'(rdy_cnt0 - c0), 64'd2);
        bus(0, CLINT_MSIP, 4'h0, 32'h0, 32'h0, "unmapped_msip");
        bus(0, CLINT_MTIMECMP_LO, 4'h0, 32'h0, 32'd100, "unmapped_cmp_lo");
        bus(0, CLINT_MTIMECMP_HI, 4'h0, 32'h0, 32'd1, "unmapped_cmp_hi");

        repeat (3) @(posedge clk);
        #1;
        check("sb0_drained", 64'(sb0.size()), 64'd0);
        check("sb1_drained", 64'(sb1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
